pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage core. It merges stall requests from the decode stage (load-use bubble) and the execute stage (multi-cycle operations such as div/madd), and produces the 6-bit stall vector that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also owns the flush/redirect path for exceptions and keeps a stall-cycle performance counter. It sits beside the decode stage and drives every pipeline register's hold input.

---
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
// Merges decode and execute stall requests into the per-stage hold vector,
// owns the exception flush/redirect path, and counts stalled cycles.
module pipe_ctrl #(
  parameter int EX_CNT_W = 6,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id_i,
  input  logic                ex_start_i,
  input  logic [EX_CNT_W-1:0] ex_cycles_i,
  input  logic                flush_i,
  input  logic [31:0]         flush_pc_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic [31:0]         new_pc_o,
  output logic                ex_busy_o,
  output logic                ex_last_o,
  output logic [PERF_W-1:0]   stall_cycles_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Hold patterns: decode bubble freezes PC/IF/ID, execute stall adds EX.
  localparam logic [5:0] HOLD_ID = 6'b000111;
  localparam logic [5:0] HOLD_EX = 6'b001111;

  localparam logic [EX_CNT_W-1:0] CNT_ONE = EX_CNT_W'(1);

  state_t              state, state_nx;
  logic [EX_CNT_W-1:0] cnt, cnt_nx;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    if (&v) return v;
    return v + PERF_W'(1);
  endfunction

  // Next-state, countdown and combinational stall/last outputs.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    stall_o   = 6'b000000;
    ex_last_o = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (flush_i) begin
            state_nx = FLUSH;
            cnt_nx   = '0;
          end else if (ex_start_i && (ex_cycles_i != '0)) begin
            stall_o = HOLD_EX;
            if (ex_cycles_i == CNT_ONE) begin
              // Single-cycle hold: the start cycle is also the last one.
              ex_last_o = 1'b1;
            end else begin
              // The start cycle already counts as one held cycle.
              cnt_nx   = ex_cycles_i - CNT_ONE;
              state_nx = EX_BUSY;
            end
          end else if (stallreq_id_i) begin
            stall_o = HOLD_ID;
          end
        end
        EX_BUSY: begin
          if (flush_i) begin
            // Exception aborts the multi-cycle op; EX never writes back.
            state_nx = FLUSH;
            cnt_nx   = '0;
          end else begin
            stall_o = HOLD_EX;
            cnt_nx  = cnt - CNT_ONE;
            if (cnt <= CNT_ONE) begin
              ex_last_o = 1'b1;
              state_nx  = RUN;
            end
          end
        end
        FLUSH: begin
          // A back-to-back flush extends the flush by one more cycle.
          state_nx = flush_i ? FLUSH : RUN;
          cnt_nx   = '0;
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // State, countdown and registered flush/redirect/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      flush_o   <= 1'b0;
      new_pc_o  <= 32'h0;
      ex_busy_o <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      flush_o   <= (state_nx == FLUSH);
      ex_busy_o <= (state_nx == EX_BUSY);
      if (flush_i) new_pc_o <= flush_pc_i;
    end
  end

  // Performance counter of cycles in which any stage was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_o <= '0;
    end else if (stall_o != 6'b000000) begin
      stall_cycles_o <= sat_inc(stall_cycles_o);
    end
  end

endmodule
